// File: rtl/mmio_port_responder.sv
// MMIO responder: 16-byte window with output FIFO, synchronized input port and CTRL/STATUS registers.
// Optional interrupt output is built only when MMIO_IRQ_EN is defined.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IN_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                out_valid,
  input  logic                out_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         last_push_q, last_push_d;
  logic                overflow_q, overflow_d;
  logic                in_changed_q, in_changed_d;
  logic [IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [31:0]         mem_q [FIFO_DEPTH];

  logic [1:0] offset;
  logic       wr_acc, rd_acc, ctrl_wr, flush;
  logic       full, empty, pop, push_req, push;
  logic       irq_en;
  logic [4:0] count5;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  always_comb begin
    Hit       = (Address[31:4] == BASE_ADDR[31:4]);
    offset    = Address[3:2];
    wr_acc    = Hit & MemWrite;
    // a simultaneous write suppresses read side effects
    rd_acc    = Hit & MemRead & ~MemWrite;
    ctrl_wr   = wr_acc & (offset == 2'd3);
    flush     = ctrl_wr & WriteData[0];
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == '0);
    out_valid = ~empty;
    pop       = out_valid & out_ready;
    push_req  = wr_acc & (offset == 2'd0);
    push      = push_req & (~full | pop);
    count5    = 5'(count_q);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_push_d  = last_push_q;
    overflow_d   = overflow_q;
    in_changed_d = in_changed_q;
    sync1_d      = PortIn;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    if (push) last_push_d = WriteData;

    if (push_req && full && !pop)     overflow_d = 1'b1;
    else if (ctrl_wr && WriteData[1]) overflow_d = 1'b0;

    // a fresh change outranks a DATA_IN read in the same cycle
    if (sync2_q != prev_q)                      in_changed_d = 1'b1;
    else if (rd_acc && (offset == 2'd2))        in_changed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_push_q  <= '0;
      overflow_q   <= 1'b0;
      in_changed_q <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_push_q  <= last_push_d;
      overflow_q   <= overflow_d;
      in_changed_q <= in_changed_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
    end
  end

  // storage is not reset; occupancy is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteData;
  end

`ifdef MMIO_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? WriteData[2] : irq_en_q;
    irq_d    = irq_en_q & (in_changed_q | overflow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      case (offset)
        2'd0:    ReadData = last_push_q;
        2'd1:    ReadData = {23'b0, count5, overflow_q, in_changed_q, empty, full};
        2'd2:    ReadData = 32'(sync2_q);
        default: ReadData = {29'b0, irq_en, 2'b0};
      endcase
    end
  end

  assign PortOut = out_valid ? mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed vector table, hand sequences for multi-cycle corners,
// and random bus traffic checked against a queue-based reference model.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam logic [31:0] A_OUT = BASE;
  localparam logic [31:0] A_ST  = BASE | 32'h4;
  localparam logic [31:0] A_IN  = BASE | 32'h8;
  localparam logic [31:0] A_CT  = BASE | 32'hC;
  localparam logic [31:0] A_OFF = 32'h1001_0110;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit, out_valid, out_ready;
  logic [7:0]  PortIn;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MMIO_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr, rd;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] exp_rd;
    logic        exp_hit, exp_valid;
    logic [31:0] exp_po;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] a, logic w, logic r, logic [31:0] d, logic rdy,
                              logic [31:0] erd, logic eh, logic ev, logic [31:0] epo);
    vec_t v;
    v = '{addr: a, wr: w, rd: r, wd: d, ready: rdy, exp_rd: erd, exp_hit: eh, exp_valid: ev, exp_po: epo};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d,
                       input logic rdy, input logic [7:0] pin);
    Address = a; MemWrite = w; MemRead = r; WriteData = d; out_ready = rdy; PortIn = pin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: FIFO as a queue, input path as a delay line of sampled PortIn values
  logic [31:0] mq[$];
  logic [31:0] m_last;
  logic        m_ovf, m_chg, m_irq_en, m_irq;
  logic [7:0]  m_hist [3];

  task automatic model_reset();
    mq.delete();
    m_last = 0; m_ovf = 0; m_chg = 0; m_irq_en = 0; m_irq = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a, logic r);
    int n;
    n = mq.size();
    if (!r || a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return m_last;
      2'd1:    return (n << 4) | (m_ovf << 3) | (m_chg << 2) | ((n == 0) << 1) | (n == DEPTH);
      2'd2:    return {24'h0, m_hist[1]};
      default: return m_irq_en ? 32'h4 : 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d,
                            input logic rdy, input logic [7:0] pin);
    logic hit, pop, set, clr, nirq;
    int   n;
    hit  = (a[31:4] == BASE[31:4]);
    n    = mq.size();
    pop  = (n > 0) && rdy;
    nirq = m_irq_en & (m_chg | m_ovf);
    set  = (m_hist[1] != m_hist[2]);
    clr  = hit && r && !w && (a[3:2] == 2'd2);
    if (hit && w && a[3:2] == 2'd3 && d[0]) mq.delete();
    else if (pop) void'(mq.pop_front());
    if (hit && w && a[3:2] == 2'd3) begin
      if (d[1]) m_ovf = 1'b0;
`ifdef MMIO_IRQ_EN
      m_irq_en = d[2];
`endif
    end
    if (hit && w && a[3:2] == 2'd0) begin
      if (n < DEPTH || pop) begin
        mq.push_back(d);
        m_last = d;
      end else m_ovf = 1'b1;
    end
    m_chg = set ? 1'b1 : (clr ? 1'b0 : m_chg);
    m_irq = nirq;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pin;
  endtask

  task automatic do_reset();
    drive(32'h0, 0, 0, 32'h0, 0, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_words [4];
    logic [31:0] a, d;
    logic        w, r, rdy;
    logic [7:0]  pin;

    tbl.push_back(mk(A_ST,  0, 1, 0,            0, 32'h2,         1, 0, 0));
    tbl.push_back(mk(A_OUT, 1, 0, 32'hA5A50001, 0, 0,             1, 0, 0));
    tbl.push_back(mk(A_OUT, 1, 0, 32'hA5A50002, 0, 0,             1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OUT, 1, 0, 32'hA5A50003, 0, 0,             1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OUT, 1, 0, 32'hA5A50004, 0, 0,             1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_ST,  0, 1, 0,            0, 32'h41,        1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OUT, 1, 0, 32'hA5A50005, 0, 0,             1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_ST,  0, 1, 0,            0, 32'h49,        1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OUT, 0, 1, 0,            0, 32'hA5A50004,  1, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OFF, 0, 1, 0,            0, 0,             0, 1, 32'hA5A50001));
    tbl.push_back(mk(A_OFF, 1, 0, 32'h12345678, 0, 0,             0, 1, 32'hA5A50001));
    tbl.push_back(mk(A_ST,  0, 1, 0,            0, 32'h49,        1, 1, 32'hA5A50001));
    tbl.push_back(mk(32'h0, 0, 0, 0,            1, 0,             0, 1, 32'hA5A50001));
    tbl.push_back(mk(32'h0, 0, 0, 0,            1, 0,             0, 1, 32'hA5A50002));
    tbl.push_back(mk(32'h0, 0, 0, 0,            1, 0,             0, 1, 32'hA5A50003));
    tbl.push_back(mk(32'h0, 0, 0, 0,            1, 0,             0, 1, 32'hA5A50004));
    tbl.push_back(mk(32'h0, 0, 0, 0,            1, 0,             0, 0, 0));
    tbl.push_back(mk(A_ST,  0, 1, 0,            0, 32'h0A,        1, 0, 0));
    tbl.push_back(mk(A_CT,  1, 0, 32'h2,        0, 0,             1, 0, 0));
    tbl.push_back(mk(BASE | 32'h7, 0, 1, 0,     0, 32'h02,        1, 0, 0));
    tbl.push_back(mk(A_CT,  0, 1, 0,            0, 0,             1, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].addr, tbl[i].wr, tbl[i].rd, tbl[i].wd, tbl[i].ready, 8'h00);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), ReadData, tbl[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), {31'b0, Hit}, {31'b0, tbl[i].exp_hit});
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_portout", i), PortOut, tbl[i].exp_po);
      tick();
    end

    // async reset with three words queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(A_OUT, 1, 0, 32'hC0DE_0000 + i, 0, 8'h00);
      tick();
    end
    drive(A_ST, 0, 1, 0, 0, 8'h00);
    #1 chk("rst_pre_valid", {31'b0, out_valid}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_status", ReadData, 32'h2);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    // push and pop into a full FIFO in the same cycle
    do_reset();
    exp_words = '{32'h22, 32'h33, 32'h44, 32'hDEAD_BEEF};
    for (int i = 1; i <= 4; i++) begin
      drive(A_OUT, 1, 0, 32'h11 * i, 0, 8'h00);
      tick();
    end
    drive(A_OUT, 1, 0, 32'hDEAD_BEEF, 1, 8'h00);
    @(negedge clk);
    chk("pp_head", PortOut, 32'h11);
    tick();
    drive(A_ST, 0, 1, 0, 0, 8'h00);
    @(negedge clk);
    chk("pp_status", ReadData, 32'h41);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'h0, 0, 0, 0, 1, 8'h00);
      @(negedge clk);
      chk($sformatf("pp_drain%0d", i), PortOut, exp_words[i]);
      tick();
    end
    drive(32'h0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    chk("pp_empty", {31'b0, out_valid}, 32'h0);

    // input synchronizer and change flag
    do_reset();
    drive(32'h0, 0, 0, 0, 0, 8'h3C);
    tick();
    tick();
    drive(A_IN, 0, 1, 0, 0, 8'h3C);
    @(negedge clk);
    chk("in_data", ReadData, 32'h3C);
    tick();
    drive(A_ST, 0, 1, 0, 0, 8'h3C);
    @(negedge clk);
    chk("in_set_wins", ReadData, 32'h6);
    tick();
    drive(A_IN, 0, 1, 0, 0, 8'h3C);
    tick();
    drive(A_ST, 0, 1, 0, 0, 8'h3C);
    @(negedge clk);
    chk("in_cleared", ReadData, 32'h2);
    tick();
    drive(32'h0, 0, 0, 0, 0, 8'h3D);
    tick();
    tick();
    drive(A_IN, 0, 1, 0, 0, 8'h3D);
    @(negedge clk);
    chk("in_toggle_data", ReadData, 32'h3D);
    tick();
    drive(A_ST, 0, 1, 0, 0, 8'h3D);
    @(negedge clk);
    chk("in_toggle_stays", ReadData, 32'h6);
    tick();

    // flush with two entries queued
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(A_OUT, 1, 0, 32'h7700 + i, 0, 8'h00);
      tick();
    end
    drive(A_CT, 1, 0, 32'h1, 1, 8'h00);
    tick();
    drive(A_ST, 0, 1, 0, 0, 8'h00);
    @(negedge clk);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_portout", PortOut, 32'h0);
    chk("flush_status", ReadData, 32'h2);
    tick();

    do_reset();
    drive(A_CT, 1, 0, 32'h4, 0, 8'h00);
    tick();
    drive(A_CT, 0, 1, 0, 0, 8'h00);
    @(negedge clk);
`ifdef MMIO_IRQ_EN
    chk("ctrl_irq_en", ReadData, 32'h4);
    tick();
    drive(32'h0, 0, 0, 0, 0, 8'h55);
    tick();
    tick();
    tick();
    chk("irq_lag", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    drive(A_IN, 0, 1, 0, 0, 8'h55);
    tick();
    drive(32'h0, 0, 0, 0, 0, 8'h55);
    tick();
    chk("irq_clear", {31'b0, irq}, 32'h0);
`else
    chk("ctrl_no_irq_en", ReadData, 32'h0);
    tick();
`endif

    // random traffic against the reference model
    do_reset();
    pin = 8'h00;
    for (int c = 0; c < 500; c++) begin
      if ($urandom % 8 == 0) a = $urandom;
      else a = BASE | 32'($urandom_range(0, 15));
      w   = ($urandom % 3 == 0);
      r   = ($urandom % 2 == 1);
      d   = $urandom;
      if (a[3:2] == 2'd3) d[0] = ($urandom % 8 == 0);
      rdy = ($urandom % 3 == 0);
      if ($urandom % 4 == 0) pin = 8'($urandom);
      drive(a, w, r, d, rdy, pin);
      @(negedge clk);
      chk("rnd_rdata", ReadData, m_read(a, r));
      chk("rnd_hit", {31'b0, Hit}, {31'b0, a[31:4] == BASE[31:4]});
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("rnd_portout", PortOut, (mq.size() != 0) ? mq[0] : 32'h0);
`ifdef MMIO_IRQ_EN
      chk("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
`endif
      model_step(a, w, r, d, rdy, pin);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
